// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-add multiplier with Start/Busy/Done handshake.
// Produces a 2*WIDTH-bit product from two WIDTH-bit operands in WIDTH compute
// cycles. Signed_Mode selects two's-complement (1) or unsigned (0) operation.
// Optional feature: define SEQ_MULT_ACCUMULATE_EN to add the Acc_En input, which
// makes a completion add the new result into Product instead of overwriting it.
module seq_multiplier #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Signed_Mode,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
`ifdef SEQ_MULT_ACCUMULATE_EN
    input  logic                 Acc_En,
`endif
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]           state_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 mode_r;
    logic [WIDTH-1:0]     a_r;
    logic                 x_r;
    logic [WIDTH-1:0]     b_r;
    logic [WIDTH-1:0]     m_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [2*WIDTH-1:0]   product_r;
`ifdef SEQ_MULT_ACCUMULATE_EN
    logic                 acc_r;
`endif

    logic                 last_s;
    logic                 sub_s;
    logic [WIDTH:0]       a_ext_s;
    logic [WIDTH:0]       m_ext_s;
    logic [WIDTH:0]       sum_s;
    logic [WIDTH-1:0]     a_next_s;
    logic [WIDTH-1:0]     b_next_s;
    logic [2*WIDTH-1:0]   prod_next_s;

    // One shift-add iteration: add or subtract M at WIDTH+1 bits, then shift {S, B} right.
    always_comb begin
        last_s  = (cnt_r == CNT_LAST);
        // The final iteration of a signed multiply weighs the multiplier MSB negatively.
        sub_s   = mode_r && last_s;
        // X always mirrors A's MSB, so it serves as the sign bit of the extended accumulator.
        if (mode_r) begin
            a_ext_s = {x_r, a_r};
            m_ext_s = {m_r[WIDTH-1], m_r};
        end else begin
            a_ext_s = {1'b0, a_r};
            m_ext_s = {1'b0, m_r};
        end
        if (b_r[0]) begin
            if (sub_s) begin
                sum_s = a_ext_s - m_ext_s;
            end else begin
                sum_s = a_ext_s + m_ext_s;
            end
        end else begin
            sum_s = a_ext_s;
        end
        a_next_s = sum_s[WIDTH:1];
        b_next_s = {sum_s[0], b_r[WIDTH-1:1]};
`ifdef SEQ_MULT_ACCUMULATE_EN
        if (acc_r) begin
            prod_next_s = product_r + {a_next_s, b_next_s};
        end else begin
            prod_next_s = {a_next_s, b_next_s};
        end
`else
        prod_next_s = {a_next_s, b_next_s};
`endif
    end

    // Control FSM: IDLE -> COMPUTE on Start, COMPUTE -> DONE after WIDTH iterations, DONE -> IDLE.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (Start) begin
                        state_r <= ST_COMPUTE;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                    done_r <= 1'b0;
                end
                ST_COMPUTE: begin
                    if (last_s) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_COMPUTE;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: capture operands and mode at the start edge, then iterate while computing.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mode_r <= 1'b0;
            a_r    <= '0;
            x_r    <= 1'b0;
            b_r    <= '0;
            m_r    <= '0;
            cnt_r  <= '0;
`ifdef SEQ_MULT_ACCUMULATE_EN
            acc_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (Start) begin
                        mode_r <= Signed_Mode;
                        m_r    <= Multiplicand;
                        b_r    <= Multiplier;
                        a_r    <= '0;
                        x_r    <= 1'b0;
                        cnt_r  <= '0;
`ifdef SEQ_MULT_ACCUMULATE_EN
                        acc_r  <= Acc_En;
`endif
                    end else begin
                        mode_r <= mode_r;
                    end
                end
                ST_COMPUTE: begin
                    x_r   <= sum_s[WIDTH];
                    a_r   <= a_next_s;
                    b_r   <= b_next_s;
                    cnt_r <= cnt_r + CNT_ONE;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Result register: updated only on the completing iteration, otherwise held.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            product_r <= '0;
        end else if ((state_r == ST_COMPUTE) && last_s) begin
            product_r <= prod_next_s;
        end else begin
            product_r <= product_r;
        end
    end

    assign Busy    = busy_r;
    assign Done    = done_r;
    assign Product = product_r;

endmodule
